imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit that replaces the fixed 16->32 combinational sign extender in the decode path.
- Accepts an IN_W-bit immediate, a 2-bit extension mode and a tag, and returns an OUT_W-bit result through a valid/ready interface.
- A 2-entry output buffer gives full throughput and lets the stage sit between decode and execute without combinational ready paths.

Parameters:
- IN_W, 16, immediate input width; must be >= 2.
- OUT_W, 32, result width; must satisfy OUT_W >= IN_W+2, otherwise elaboration fails.
- TAG_W, 5, width of the sideband tag (e.g. destination register index), passed through unchanged.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream offers an immediate.
- in_ready  output  1  unit can accept; equals (count < 2), driven only from registers.
- in_imm  input  IN_W  immediate value.
- in_mode  input  2  extension mode (ext_mode_t).
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  head buffer entry holds a result.
- out_ready  input  1  downstream accepts the head entry.
- out_data  output  OUT_W  extended result of the head entry.
- out_tag  output  TAG_W  tag of the head entry.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset: at a rising edge with rst_n=0, count=0, both entries' data and tag are cleared to 0, and a pending push is discarded.
  - After that edge: out_valid=0, out_data=0, out_tag=0, in_ready=1.
  - Reset mid-operation drops buffered results; no partial output is produced.
- Transfers:
  - Push: in_valid && in_ready at an edge.
  - Pop: out_valid && out_ready at an edge.
- Modes (result computed combinationally from in_imm, then written into the buffer on push):
  - 2'b00 EXT_SIGN: replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
  - 2'b01 EXT_ZERO: upper OUT_W-IN_W bits are 0.
  - 2'b10 EXT_UPPER: {in_imm, (OUT_W-IN_W) zeros}, i.e. the load-upper form.
  - 2'b11 EXT_BRANCH: sign-extend, then shift left by 2; the two LSBs are 0 and the top two sign-extended bits are discarded.
- Latency: a push at edge N makes the result visible at out_data/out_valid after edge N (1 cycle) when the buffer was empty. With one entry queued, the result appears after the head pops.
- Buffer: 2-entry FIFO with head/tail pointers wrapping mod 2 and a count in 0..2.
  - Push only, count<2: tail written, count+1.
  - Pop only: head advances, count-1; out_data shows the next entry in the following cycle.
  - Push and pop, count=1: both occur, count stays 1, and out_data shows the new entry next cycle.
  - Push and pop, count=0: impossible, since out_valid=0.
  - count=2: in_ready=0 and any push is ignored. A pop that cycle makes in_ready=1 after the edge.
- Ordering: strict FIFO; the tag always stays paired with its own data.
- Stability: while out_valid=1 && out_ready=0, out_data and out_tag hold constant.
- Throughput: 1 result per cycle while out_ready=1.
- in_valid=1 with in_ready=0 has no effect; upstream must hold its values until accepted.

Decomposition:
- Package ext_pkg:
  - typedef enum logic [1:0] ext_mode_t {EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_BRANCH}.
  - Localparam BUF_DEPTH=2.
- Sub-module ext_core (combinational; params IN_W, OUT_W; ports imm, mode, result) holds the mode arithmetic.
- imm_extend_pipe holds the buffer, pointers, count and handshake logic.

Test Plan:
- Reset, then out_ready=1 and four single pushes in mode EXT_SIGN with imm 0x0005, 0xFFFA, 0x7FFF, 0x8000 -> one cycle later each gives 0x00000005, 0xFFFFFFFA, 0x00007FFF, 0xFFFF8000.
- Modes on imm 0x8001:
  - EXT_ZERO -> 0x00008001.
  - EXT_UPPER -> 0x80010000.
  - EXT_BRANCH -> 0xFFFE0004.
  - EXT_BRANCH on 0xFFFF -> 0xFFFFFFFC.
- out_ready=0 with pushes of tags 1, 2, 3 -> tags 1 and 2 accepted, in_ready=0 on the third, out_data frozen at the first result. Raising out_ready drains tag1 then tag2, after which tag3 is accepted.
- in_valid and out_ready held at 1 for 16 back-to-back pushes -> 16 results in order at 1/cycle, count never exceeds 1, in_ready never drops.
- Buffer full (count=2), rst_n=0 for one edge -> out_valid=0, out_data=0, out_tag=0, in_ready=1; a push at that same edge is not delivered.
- Parameter sweep with IN_W=12, OUT_W=20: imm 0x800 in EXT_SIGN -> 0xFF800; EXT_UPPER -> 0x80000.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared types for the immediate-extension pipeline stage.
// Extension modes and the output buffer depth.
package ext_pkg;

   typedef enum logic [1:0] {
      EXT_SIGN   = 2'b00,
      EXT_ZERO   = 2'b01,
      EXT_UPPER  = 2'b10,
      EXT_BRANCH = 2'b11
   } ext_mode_t;

   localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extension.
// Produces the sign, zero, load-upper or branch-offset form of an immediate.
module ext_core
   import ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  imm,
   input  ext_mode_t        mode,
   output logic [OUT_W-1:0] result
);

   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] zext;
   logic [OUT_W-1:0] upper;
   logic [OUT_W-1:0] branch;

   assign sext   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
   assign zext   = {{(OUT_W-IN_W){1'b0}}, imm};
   assign upper  = {imm, {(OUT_W-IN_W){1'b0}}};
   // Word offset: the two top sign copies fall off the end
   assign branch = {sext[OUT_W-3:0], 2'b00};

   always_comb begin
      result = '0;
      unique case (mode)
         EXT_SIGN:   result = sext;
         EXT_ZERO:   result = zext;
         EXT_UPPER:  result = upper;
         EXT_BRANCH: result = branch;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with a 2-entry output FIFO.
// in_ready depends only on the registered count, never on out_ready.
module imm_extend_pipe
   import ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  ext_mode_t        in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);

   if (IN_W < 2 || OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_extend_pipe: need IN_W >= 2 and OUT_W >= IN_W+2");
   end

   logic [OUT_W-1:0] buf_data [BUF_DEPTH];
   logic [TAG_W-1:0] buf_tag  [BUF_DEPTH];
   logic             head;
   logic             tail;
   logic [1:0]       count;
   logic [OUT_W-1:0] result;
   logic             push;
   logic             pop;

   ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .imm    (in_imm),
      .mode   (in_mode),
      .result (result)
   );

   assign in_ready  = (count < 2'(BUF_DEPTH));
   assign out_valid = (count != 2'd0);
   assign out_data  = buf_data[head];
   assign out_tag   = buf_tag[head];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_data[i] <= '0;
            buf_tag[i]  <= '0;
         end
      end else begin
         if (push) begin
            buf_data[tail] <= result;
            buf_tag[tail]  <= in_tag;
            tail           <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         count <= count + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe.
// Outputs are compared against an arithmetic model and a FIFO queue.
module tb_imm_extend_pipe;
   import ext_pkg::*;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  t;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_imm = '0;
   ext_mode_t   in_mode = EXT_SIGN;
   logic [4:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [4:0]  out_tag;

   logic        p_in_valid = 1'b0;
   logic        p_in_ready;
   logic [11:0] p_in_imm = '0;
   ext_mode_t   p_in_mode = EXT_SIGN;
   logic [4:0]  p_in_tag = '0;
   logic        p_out_valid;
   logic        p_out_ready = 1'b1;
   logic [19:0] p_out_data;
   logic [4:0]  p_out_tag;

   int   checks = 0;
   int   errors = 0;
   ent_t q[$];

   always #5 clk = ~clk;

   imm_extend_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imm    (in_imm),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   imm_extend_pipe #(
      .IN_W  (12),
      .OUT_W (20),
      .TAG_W (5)
   ) dut_p (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (p_in_valid),
      .in_ready  (p_in_ready),
      .in_imm    (p_in_imm),
      .in_mode   (p_in_mode),
      .in_tag    (p_in_tag),
      .out_valid (p_out_valid),
      .out_ready (p_out_ready),
      .out_data  (p_out_data),
      .out_tag   (p_out_tag)
   );

   // Extension by value: interpret the immediate as a number, scale, wrap.
   function automatic logic [63:0] ref_ext(int iw, int ow,
                                           logic [63:0] imm,
                                           ext_mode_t m);
      longint v;
      longint r;
      v = longint'(imm);
      if (imm[iw-1]) v = v - (longint'(1) << iw);
      case (m)
         EXT_SIGN:   r = v;
         EXT_ZERO:   r = longint'(imm);
         EXT_UPPER:  r = longint'(imm) * (longint'(1) << (ow - iw));
         default:    r = v * 4;
      endcase
      return 64'(r) & ((64'd1 << ow) - 64'd1);
   endfunction

   task automatic tick();
      bit          push;
      bit          pop;
      ent_t        e;
      logic [63:0] r;
      push = in_valid && (q.size() < 2);
      pop  = (q.size() > 0) && out_ready;
      r    = ref_ext(16, 32, 64'(in_imm), in_mode);
      e.d  = r[31:0];
      e.t  = in_tag;
      @(posedge clk);
      if (!rst_n) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(e);
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 ||
          out_tag !== 5'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: valid=%b data=%h tag=%h ready=%b",
                  out_valid, out_data, out_tag, in_ready);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_sign();
      logic [15:0] imms [4] = '{16'h0005, 16'hFFFA, 16'h7FFF, 16'h8000};
      logic [31:0] exps [4] = '{32'h00000005, 32'hFFFFFFFA,
                                32'h00007FFF, 32'hFFFF8000};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_imm   = imms[i];
         in_mode  = EXT_SIGN;
         in_tag   = 5'(i);
         tick();
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || out_data !== exps[i] ||
             out_tag !== 5'(i)) begin
            errors++;
            $display("FAIL sign[%0d]: valid=%b data=%h tag=%h want %h/%0d",
                     i, out_valid, out_data, out_tag, exps[i], i);
         end
         tick();
      end
   endtask

   task automatic test_modes();
      logic [15:0] imms [4] = '{16'h8001, 16'h8001, 16'h8001, 16'hFFFF};
      ext_mode_t   mds  [4] = '{EXT_ZERO, EXT_UPPER, EXT_BRANCH, EXT_BRANCH};
      logic [31:0] exps [4] = '{32'h00008001, 32'h80010000,
                                32'hFFFE0004, 32'hFFFFFFFC};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_imm   = imms[i];
         in_mode  = mds[i];
         in_tag   = 5'(10 + i);
         tick();
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || out_data !== exps[i]) begin
            errors++;
            $display("FAIL mode[%0d]: valid=%b data=%h want %h",
                     i, out_valid, out_data, exps[i]);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_mode   = EXT_SIGN;
      for (int t = 1; t <= 2; t++) begin
         in_valid = 1'b1;
         in_imm   = 16'(t * 16'h1111);
         in_tag   = 5'(t);
         tick();
      end
      in_imm = 16'h3333;
      in_tag = 5'd3;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
             out_data !== 32'h00001111 || out_tag !== 5'd1) begin
            errors++;
            $display("FAIL full_hold[%0d]: ready=%b data=%h tag=%0d want 0/00001111/1",
                     k, in_ready, out_data, out_tag);
         end
         tick();
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 2) in_valid = 1'b0;
         checks++;
         if (out_valid !== (q.size() > 0) ||
             (q.size() > 0 && (out_data !== q[0].d || out_tag !== q[0].t))) begin
            errors++;
            $display("FAIL drain[%0d]: valid=%b data=%h tag=%0d",
                     k, out_valid, out_data, out_tag);
         end
      end
      checks++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_empty: valid=%b model=%0d", out_valid, q.size());
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_imm   = 16'($urandom);
         in_mode  = ext_mode_t'($urandom_range(0, 3));
         in_tag   = 5'(i);
         tick();
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b1 || q.size() > 1 ||
             out_data !== q[0].d || out_tag !== 5'(i) || q[0].t !== 5'(i)) begin
            errors++;
            $display("FAIL b2b[%0d]: ready=%b valid=%b data=%h tag=%0d want %h/%0d",
                     i, in_ready, out_valid, out_data, out_tag, q[0].d, i);
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         if (!(in_valid && q.size() >= 2)) begin
            in_valid = 1'($urandom_range(0, 1));
            in_imm   = 16'($urandom);
            in_mode  = ext_mode_t'($urandom_range(0, 3));
            in_tag   = 5'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         checks++;
         if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0) ||
             (q.size() > 0 && (out_data !== q[0].d || out_tag !== q[0].t))) begin
            errors++;
            $display("FAIL rand[%0d]: ready=%b valid=%b data=%h tag=%0d depth=%0d",
                     i, in_ready, out_valid, out_data, out_tag, q.size());
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_reset_full();
      out_ready = 1'b0;
      for (int t = 0; t < 2; t++) begin
         in_valid = 1'b1;
         in_imm   = 16'hABCD;
         in_tag   = 5'(20 + t);
         tick();
      end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL prefill: ready=%b valid=%b want 0/1", in_ready, out_valid);
      end
      rst_n  = 1'b0;
      in_tag = 5'd31;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 ||
          out_tag !== 5'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_full: valid=%b data=%h tag=%h ready=%b",
                  out_valid, out_data, out_tag, in_ready);
      end
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_push_drop: valid=%b tag=%0d want 0",
                  out_valid, out_tag);
      end
   endtask

   task automatic test_param();
      logic [63:0] r;
      p_out_ready = 1'b1;
      p_in_valid  = 1'b1;
      p_in_imm    = 12'h800;
      p_in_mode   = EXT_SIGN;
      @(posedge clk);
      #1;
      p_in_mode = EXT_UPPER;
      r = ref_ext(12, 20, 64'h800, EXT_SIGN);
      checks++;
      if (p_out_valid !== 1'b1 || p_out_data !== 20'hFF800 ||
          p_out_data !== r[19:0]) begin
         errors++;
         $display("FAIL param_sign: valid=%b data=%h want FF800",
                  p_out_valid, p_out_data);
      end
      @(posedge clk);
      #1;
      p_in_valid = 1'b0;
      r = ref_ext(12, 20, 64'h800, EXT_UPPER);
      checks++;
      if (p_out_valid !== 1'b1 || p_out_data !== 20'h80000 ||
          p_out_data !== r[19:0]) begin
         errors++;
         $display("FAIL param_upper: valid=%b data=%h want 80000",
                  p_out_valid, p_out_data);
      end
   endtask

   initial begin
      test_reset();
      test_sign();
      test_modes();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_full();
      test_param();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
